// File: rtl/dpram_sync_be.sv
// True dual-port single-clock RAM with byte enables, selectable
// read-during-write behaviour, optional output register and clear engine.
module dpram_sync_be #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter bit WRITE_MODE     = 1'b0,
    parameter bit OUT_REG        = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    init_busy,
    input  logic                    en_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH/8-1:0] we_a,
    input  logic [DATA_WIDTH-1:0]   di_a,
    output logic [DATA_WIDTH-1:0]   do_a,
    output logic                    valid_a,
    input  logic                    en_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH/8-1:0] we_b,
    input  logic [DATA_WIDTH-1:0]   di_b,
    output logic [DATA_WIDTH-1:0]   do_b,
    output logic                    valid_b
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    clr_en;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    acc_a, acc_b;
    logic                    wr_a, wr_b;
    logic [DATA_WIDTH-1:0]   old_a, old_b;
    logic [DATA_WIDTH-1:0]   fin_a, fin_b;
    logic [DATA_WIDTH-1:0]   rd_a, rd_b;

    logic [DATA_WIDTH-1:0]   p_a_q, p_a_d, p_b_q, p_b_d;
    logic                    pv_a_q, pv_a_d, pv_b_q, pv_b_d;
    logic [DATA_WIDTH-1:0]   do_a_q, do_a_d, do_b_q, do_b_d;
    logic                    valid_a_q, valid_a_d, valid_b_q, valid_b_d;

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [NBYTES-1:0]     we
    );
        logic [DATA_WIDTH-1:0] res;
        res = old;
        for (int i = 0; i < NBYTES; i++) begin
            if (we[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    // Clear engine: one word per cycle, READY after the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        if (state_q == CLEAR) begin
            clr_en = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = READY;
                cnt_d   = '0;
            end
        end
    end

    assign init_busy = CLEAR_ON_RESET && (rst || state_q == CLEAR);

    // Final word per address: B lanes applied first so A wins shared lanes.
    always_comb begin
        acc_a = en_a && (state_q == READY) && !rst;
        acc_b = en_b && (state_q == READY) && !rst;
        wr_a  = acc_a && (|we_a);
        wr_b  = acc_b && (|we_b);
        old_a = mem_q[addr_a];
        old_b = mem_q[addr_b];

        fin_a = old_a;
        if (acc_b && addr_b == addr_a) fin_a = merge(fin_a, di_b, we_b);
        if (acc_a) fin_a = merge(fin_a, di_a, we_a);

        fin_b = old_b;
        if (acc_b) fin_b = merge(fin_b, di_b, we_b);
        if (acc_a && addr_a == addr_b) fin_b = merge(fin_b, di_a, we_a);

        rd_a = WRITE_MODE ? fin_a : old_a;
        rd_b = WRITE_MODE ? fin_b : old_b;
    end

    always_comb begin
        p_a_d  = rd_a;
        p_b_d  = rd_b;
        pv_a_d = acc_a;
        pv_b_d = acc_b;
        if (OUT_REG) begin
            valid_a_d = pv_a_q;
            valid_b_d = pv_b_q;
            do_a_d    = pv_a_q ? p_a_q : do_a_q;
            do_b_d    = pv_b_q ? p_b_q : do_b_q;
        end else begin
            valid_a_d = acc_a;
            valid_b_d = acc_b;
            do_a_d    = acc_a ? rd_a : do_a_q;
            do_b_d    = acc_b ? rd_b : do_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
            cnt_q     <= '0;
            p_a_q     <= '0;
            p_b_q     <= '0;
            pv_a_q    <= 1'b0;
            pv_b_q    <= 1'b0;
            do_a_q    <= '0;
            do_b_q    <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_a_q     <= p_a_d;
            p_b_q     <= p_b_d;
            pv_a_q    <= pv_a_d;
            pv_b_q    <= pv_b_d;
            do_a_q    <= do_a_d;
            do_b_q    <= do_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_en) mem_q[cnt_q] <= '0;
            if (wr_b) mem_q[addr_b] <= fin_b;
            if (wr_a) mem_q[addr_a] <= fin_a;
        end
    end

    assign do_a    = do_a_q;
    assign do_b    = do_b_q;
    assign valid_a = valid_a_q;
    assign valid_b = valid_b_q;

endmodule
